// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer: launches 74xx tester slots (manual or auto scan),
// collects Done/RSLT, releases each tester and guards against hangs.
//
// Ports:
//   Clk, Reset        clock, async active-high reset
//   Start, Ack        run request (edge detected) / report acknowledge
//   Auto, Sel         scan mode and manual slot, sampled at launch
//   Done_in, Rslt_in  per-slot tester status
//   Run, Disp_Rslt    one-hot run / release to the active slot
//   Busy, Result_Valid, Pass, Timeout, Sel_Err, Chip_Idx, Pass_Map  status
module chip_test_sequencer #(
  parameter int NUM_CHIPS      = 8,
  parameter int SEL_W          = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Auto,
  input  logic [SEL_W-1:0]     Sel,
  input  logic                 Ack,
  input  logic [NUM_CHIPS-1:0] Done_in,
  input  logic [NUM_CHIPS-1:0] Rslt_in,
  output logic [NUM_CHIPS-1:0] Run,
  output logic [NUM_CHIPS-1:0] Disp_Rslt,
  output logic                 Busy,
  output logic                 Result_Valid,
  output logic                 Pass,
  output logic                 Timeout,
  output logic                 Sel_Err,
  output logic [SEL_W-1:0]     Chip_Idx,
  output logic [NUM_CHIPS-1:0] Pass_Map
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_REPORT  = 3'd5;

  logic [2:0]           state;
  logic [SEL_W-1:0]     idx;
  logic [CNT_W-1:0]     cnt;
  logic                 start_q;
  logic                 auto_q;
  logic                 start_rise;
  logic                 cnt_hit;
  logic                 done_sel;
  logic                 rslt_sel;
  logic                 last_slot;
  logic                 sel_ok;
  logic [NUM_CHIPS-1:0] slot_oh;
  logic [SEL_W-1:0]     lowest;

  // Mask form keeps out-of-range indices harmless: they select nothing.
  assign slot_oh    = NUM_CHIPS'(1) << idx;
  assign start_rise = Start & ~start_q;
  assign done_sel   = |(Done_in & slot_oh);
  assign rslt_sel   = |(Rslt_in & slot_oh);
  assign cnt_hit    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign last_slot  = (int'(idx) >= NUM_CHIPS - 1);
  assign sel_ok     = (int'(Sel) < NUM_CHIPS);

  always_comb begin
    lowest = '0;
    for (int i = NUM_CHIPS - 1; i >= 0; i--) begin
      if (Pass_Map[i]) lowest = SEL_W'(i);
    end
  end

  // Decoded from state so both drop the instant Reset hits.
  assign Run          = (state == S_LAUNCH) ? slot_oh : '0;
  assign Disp_Rslt    = (state == S_RELEASE) ? (Done_in & slot_oh) : '0;
  assign Busy         = (state != S_IDLE) && (state != S_REPORT);
  assign Result_Valid = (state == S_REPORT);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      start_q  <= 1'b0;
      auto_q   <= 1'b0;
      Pass     <= 1'b0;
      Timeout  <= 1'b0;
      Sel_Err  <= 1'b0;
      Chip_Idx <= '0;
      Pass_Map <= '0;
    end else begin
      start_q <= Start;
      unique case (state)
        S_IDLE, S_REPORT: begin
          if (start_rise) begin
            Pass_Map <= '0;
            Timeout  <= 1'b0;
            Sel_Err  <= 1'b0;
            auto_q   <= Auto;
            if (Auto) begin
              idx   <= '0;
              state <= S_LAUNCH;
            end else if (sel_ok) begin
              idx   <= Sel;
              state <= S_LAUNCH;
            end else begin
              idx      <= Sel;
              Sel_Err  <= 1'b1;
              Pass     <= 1'b0;
              Chip_Idx <= Sel;
              state    <= S_REPORT;
            end
          end else if ((state == S_REPORT) && Ack) begin
            state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (done_sel) begin
            Pass_Map <= rslt_sel ? (Pass_Map | slot_oh)
                                 : (Pass_Map & ~slot_oh);
            state    <= S_RELEASE;
          end else if (cnt_hit) begin
            Timeout  <= 1'b1;
            Pass_Map <= Pass_Map & ~slot_oh;
            state    <= S_NEXT;
          end
        end
        // Counter keeps running so WAIT+RELEASE share one budget.
        S_RELEASE: begin
          cnt <= cnt + CNT_W'(1);
          if (!done_sel) begin
            state <= S_NEXT;
          end else if (cnt_hit) begin
            Timeout <= 1'b1;
            state   <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (auto_q && !last_slot) begin
            idx   <= idx + SEL_W'(1);
            state <= S_LAUNCH;
          end else begin
            Pass     <= auto_q ? (|Pass_Map) : (|(Pass_Map & slot_oh));
            Chip_Idx <= auto_q ? lowest : idx;
            state    <= S_REPORT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// tb_chip_test_sequencer: directed bench for chip_test_sequencer
// with a behavioural tester bank on an 8-slot and a 6-slot instance.
module tb_chip_test_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, auto_m, ack;
  logic [2:0] sel;
  logic [7:0] done, rslt, run, disp, pmap;
  logic       busy, rv, pass, tmo, serr;
  logic [2:0] cidx;

  logic       start6, auto6, ack6;
  logic [2:0] sel6;
  logic [5:0] done6, rslt6, run6, disp6, pmap6;
  logic       busy6, rv6, pass6, tmo6, serr6;
  logic [2:0] cidx6;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chip_test_sequencer #(
    .NUM_CHIPS(8), .SEL_W(3), .TIMEOUT_CYCLES(16)
  ) u8 (
    .Clk(clk), .Reset(rst), .Start(start), .Auto(auto_m),
    .Sel(sel), .Ack(ack), .Done_in(done), .Rslt_in(rslt),
    .Run(run), .Disp_Rslt(disp), .Busy(busy),
    .Result_Valid(rv), .Pass(pass), .Timeout(tmo),
    .Sel_Err(serr), .Chip_Idx(cidx), .Pass_Map(pmap)
  );

  chip_test_sequencer #(
    .NUM_CHIPS(6), .SEL_W(3), .TIMEOUT_CYCLES(16)
  ) u6 (
    .Clk(clk), .Reset(rst), .Start(start6), .Auto(auto6),
    .Sel(sel6), .Ack(ack6), .Done_in(done6), .Rslt_in(rslt6),
    .Run(run6), .Disp_Rslt(disp6), .Busy(busy6),
    .Result_Valid(rv6), .Pass(pass6), .Timeout(tmo6),
    .Sel_Err(serr6), .Chip_Idx(cidx6), .Pass_Map(pmap6)
  );

  // Tester model: Done rises lat cycles after Run (lat=0: never),
  // falls after one cycle of Disp_Rslt.
  int lat [8];
  int wcnt [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= '0;
      for (int i = 0; i < 8; i++) wcnt[i] <= 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (run[i]) begin
          wcnt[i] <= lat[i];
        end else if (wcnt[i] != 0) begin
          wcnt[i] <= wcnt[i] - 1;
          if (wcnt[i] == 1) done[i] <= 1'b1;
        end
        if (disp[i]) done[i] <= 1'b0;
      end
    end
  end

  logic [7:0] run_log [$];
  int disp_cnt [8];
  int overlap  = 0;
  int run6_cnt = 0;

  initial for (int i = 0; i < 8; i++) disp_cnt[i] = 0;

  always @(negedge clk) begin
    if (run != 8'h00) run_log.push_back(run);
    for (int i = 0; i < 8; i++) begin
      if (disp[i]) disp_cnt[i]++;
    end
    if ($countones(run | disp) > 1) overlap++;
    if (run6 != 6'h00) run6_cnt++;
  end

  int disp_base [8];
  int rb;

  function automatic logic [7:0] run_at(input int k);
    return (k < run_log.size()) ? run_log[k] : 8'h00;
  endfunction

  function automatic int disp_since(input int i);
    return disp_cnt[i] - disp_base[i];
  endfunction

  function automatic int disp_total();
    int s = 0;
    for (int i = 0; i < 8; i++) s += disp_since(i);
    return s;
  endfunction

  task automatic snap();
    rb = run_log.size();
    for (int i = 0; i < 8; i++) disp_base[i] = disp_cnt[i];
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  task automatic wait_rv(input string tag, input int budget);
    int n = 0;
    while (!rv && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rv), 32'd1);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    auto_m = 1'b0;
    ack    = 1'b0;
    sel    = 3'd0;
    rslt   = 8'h00;
    start6 = 1'b0;
    auto6  = 1'b0;
    ack6   = 1'b0;
    sel6   = 3'd0;
    done6  = 6'h00;
    rslt6  = 6'h00;
    for (int i = 0; i < 8; i++) lat[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_outs", {run, disp, busy, rv, pass, tmo,
                     serr, cidx, pmap}, 32'd0);
    chk("rst_outs6", 32'({busy6, rv6, serr6, cidx6, pmap6}),
        32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Manual slot 2, Done 3 cycles after Run, passes.
    lat[2] = 3;
    rslt   = 8'h04;
    sel    = 3'd2;
    snap();
    pulse_start();
    wait_rv("t1_rv", 60);
    chk("t1_runs", 32'(run_log.size() - rb), 32'd1);
    chk("t1_run0", 32'(run_at(rb)), 32'h04);
    chk("t1_disp2", 32'(disp_since(2)), 32'd1);
    chk("t1_disp_all", 32'(disp_total()), 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_pmap", 32'(pmap), 32'h04);
    chk("t1_cidx", 32'(cidx), 32'd2);
    chk("t1_tmo", 32'(tmo), 32'd0);
    do_ack();
    chk("t1_ack_rv", 32'(rv), 32'd0);
    chk("t1_hold", 32'({pass, pmap}), 32'h104);

    // Auto scan, slots 3 and 5 pass; Start re-pulsed mid scan.
    auto_m = 1'b1;
    rslt   = 8'h28;
    for (int i = 0; i < 8; i++) lat[i] = 2;
    snap();
    pulse_start();
    repeat (10) @(negedge clk);
    chk("t2_busy", 32'(busy), 32'd1);
    pulse_start();
    wait_rv("t2_rv", 300);
    chk("t2_runs", 32'(run_log.size() - rb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_order%0d", i),
          32'(run_at(rb + i)), 32'(8'h01 << i));
    end
    chk("t2_pmap", 32'(pmap), 32'h28);
    chk("t2_cidx", 32'(cidx), 32'd3);
    chk("t2_pass", 32'(pass), 32'd1);
    chk("t2_tmo", 32'(tmo), 32'd0);
    chk("t2_disp", 32'(disp_total()), 32'd8);

    // Ack and Start together in REPORT: Start wins.
    @(negedge clk) begin
      ack   = 1'b1;
      start = 1'b1;
    end
    @(negedge clk);
    chk("t5_rv", 32'(rv), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_run", 32'(run), 32'h01);
    ack   = 1'b0;
    start = 1'b0;
    wait_rv("t5_rv2", 300);
    chk("t5_pmap", 32'(pmap), 32'h28);
    do_ack();

    // Manual slot 1 hangs: LAUNCH + 16 WAIT + NEXT, then REPORT.
    auto_m = 1'b0;
    sel    = 3'd1;
    lat[1] = 0;
    rslt   = 8'h02;
    snap();
    pulse_start();
    chk("t3_run", 32'(run), 32'h02);
    n = 0;
    while (!rv && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_lat", 32'(n), 32'd18);
    chk("t3_tmo", 32'(tmo), 32'd1);
    chk("t3_pass", 32'(pass), 32'd0);
    chk("t3_pmap", 32'(pmap), 32'h00);
    chk("t3_cidx", 32'(cidx), 32'd1);
    chk("t3_disp", 32'(disp_total()), 32'd0);
    do_ack();

    // 6-slot instance, Sel=7 is out of range.
    sel6 = 3'd7;
    @(negedge clk) start6 = 1'b1;
    @(negedge clk) start6 = 1'b0;
    chk("t4_rv", 32'(rv6), 32'd1);
    chk("t4_serr", 32'(serr6), 32'd1);
    chk("t4_busy", 32'(busy6), 32'd0);
    chk("t4_cidx", 32'(cidx6), 32'd7);
    chk("t4_rest", 32'({disp6, pmap6, tmo6, pass6}), 32'd0);
    repeat (2) @(negedge clk);
    chk("t4_norun", 32'(run6_cnt), 32'd0);

    // Reset during WAIT of slot 4, then restart from slot 0.
    auto_m = 1'b1;
    rslt   = 8'hFF;
    for (int i = 0; i < 8; i++) lat[i] = 3;
    pulse_start();
    n = 0;
    while (run != 8'h10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach4", 32'(run), 32'h10);
    chk("t6_pmap_pre", 32'(pmap), 32'h0F);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outs", {run, disp, busy, rv, pass, tmo,
                        serr, cidx, pmap}, 32'd0);
    @(negedge clk) rst = 1'b0;
    snap();
    pulse_start();
    chk("t6_run0", 32'(run), 32'h01);
    wait_rv("t6_rv", 300);
    chk("t6_runs", 32'(run_log.size() - rb), 32'd8);
    chk("t6_first", 32'(run_at(rb)), 32'h01);
    chk("t6_pmap", 32'(pmap), 32'hFF);
    chk("t6_cidx", 32'(cidx), 32'd0);
    chk("t6_pass", 32'(pass), 32'd1);

    chk("onehot", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
